leading_zero_normalizer: RTL and testbench

LEADING_ZERO_NORMALIZER -- requirements
Module: leading_zero_normalizer

---
 rtl/leading_zero_normalizer.sv | 158 +++++++++++++++
 tb/tb_leading_zero_normalizer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/leading_zero_normalizer.sv
// Iterative 32-bit normalizer: 5-step binary-search leading-zero shift.
// Define NORM_CTZ_EN to add i_dir and the trailing-zero (right shift) mode.
module leading_zero_normalizer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_in,
  input  logic        i_valid,
  output logic        o_ready,
`ifdef NORM_CTZ_EN
  input  logic        i_dir,
`endif
  output logic [31:0] o_out,
  output logic [5:0]  o_amt,
  output logic        o_zero,
  output logic        o_valid,
  input  logic        i_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] val_q, val_d;
  logic [5:0]  amt_q, amt_d;
  logic        zin_q, zin_d;
  logic [31:0] out_q, out_d;
  logic [5:0]  oamt_q, oamt_d;
  logic        ozero_q, ozero_d;
`ifdef NORM_CTZ_EN
  logic        dir_q, dir_d;
`endif

  logic [5:0]  k;
  logic [31:0] step_val;
  logic [5:0]  step_amt;
  logic        lz_hit;
`ifdef NORM_CTZ_EN
  logic        tz_hit;
`endif

  always_comb begin
    unique case (cnt_q)
      3'd0:    k = 6'd16;
      3'd1:    k = 6'd8;
      3'd2:    k = 6'd4;
      3'd3:    k = 6'd2;
      default: k = 6'd1;
    endcase
  end

  // One search step: test the top (or bottom) k bits, shift them out if all zero
  always_comb begin
    step_val = val_q;
    step_amt = amt_q;
    lz_hit   = (val_q & ~(32'hFFFF_FFFF >> k)) == 32'd0;
`ifdef NORM_CTZ_EN
    tz_hit   = (val_q & ~(32'hFFFF_FFFF << k)) == 32'd0;
    if (dir_q) begin
      if (tz_hit) begin
        step_val = val_q >> k;
        step_amt = amt_q + k;
      end
    end else if (lz_hit) begin
      step_val = val_q << k;
      step_amt = amt_q + k;
    end
`else
    if (lz_hit) begin
      step_val = val_q << k;
      step_amt = amt_q + k;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    amt_d   = amt_q;
    zin_d   = zin_q;
    out_d   = out_q;
    oamt_d  = oamt_q;
    ozero_d = ozero_q;
`ifdef NORM_CTZ_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          val_d   = i_in;
          amt_d   = 6'd0;
          cnt_d   = 3'd0;
          zin_d   = (i_in == 32'd0);
`ifdef NORM_CTZ_EN
          dir_d   = i_dir;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        val_d = step_val;
        amt_d = step_amt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          out_d   = step_val;
          // The five steps only sum to 31; a zero operand reports the full width
          oamt_d  = zin_q ? 6'd32 : step_amt;
          ozero_d = zin_q;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      val_q   <= 32'd0;
      amt_q   <= 6'd0;
      zin_q   <= 1'b0;
      out_q   <= 32'd0;
      oamt_q  <= 6'd0;
      ozero_q <= 1'b0;
`ifdef NORM_CTZ_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      amt_q   <= amt_d;
      zin_q   <= zin_d;
      out_q   <= out_d;
      oamt_q  <= oamt_d;
      ozero_q <= ozero_d;
`ifdef NORM_CTZ_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_out   = out_q;
  assign o_amt   = oamt_q;
  assign o_zero  = ozero_q;

endmodule

// File: tb/tb_leading_zero_normalizer.sv
// Self-checking bench for leading_zero_normalizer (directed + random ops).
// Trailing-zero cases are exercised when NORM_CTZ_EN is defined.
module tb_leading_zero_normalizer;

  logic        clk;
  logic        rst;
  logic [31:0] i_in;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_out;
  logic [5:0]  o_amt;
  logic        o_zero;
  logic        o_valid;
  logic        i_ready;
`ifdef NORM_CTZ_EN
  logic        dir;
`endif

  int total = 0;
  int bad   = 0;

  leading_zero_normalizer dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_in    (i_in),
    .i_valid (i_valid),
    .o_ready (o_ready),
`ifdef NORM_CTZ_EN
    .i_dir   (dir),
`endif
    .o_out   (o_out),
    .o_amt   (o_amt),
    .o_zero  (o_zero),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--)
      if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ctz(input logic [31:0] v);
    for (int i = 0; i < 32; i++)
      if (v[i]) return i;
    return 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] v,
                              input logic d);
    int          amt;
    logic [31:0] eo;
    amt = d ? ctz(v) : clz(v);
    eo  = (v == 32'd0) ? 32'd0 : (d ? (v >> amt) : (v << amt));
    chk({tag, "_vld"},  {31'd0, o_valid}, 32'd1);
    chk({tag, "_out"},  o_out, eo);
    chk({tag, "_amt"},  {26'd0, o_amt}, amt);
    chk({tag, "_zero"}, {31'd0, o_zero}, {31'd0, v == 32'd0});
  endtask

  // Accept edge plus five search edges; o_valid must be high after the sixth
  task automatic run_op(input string tag, input logic [31:0] v,
                        input logic d);
    wait_ready();
    i_in    = v;
    i_valid = 1'b1;
`ifdef NORM_CTZ_EN
    dir     = d;
`endif
    tick();
    i_valid = 1'b0;
    i_in    = $urandom;
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_lat"},  {31'd0, o_valid}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_ready}, 32'd0);
      tick();
    end
    check_result(tag, v, d);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_rdy_next"}, {31'd0, o_ready}, 32'd1);
    chk({tag, "_vld_low"},  {31'd0, o_valid}, 32'd0);
  endtask

  logic [31:0] r;
  logic [31:0] h_out;
  logic [5:0]  h_amt;

  initial begin
    rst     = 1'b1;
    i_in    = 32'd0;
    i_valid = 1'b0;
    i_ready = 1'b0;
`ifdef NORM_CTZ_EN
    dir     = 1'b0;
`endif
    #12;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_out",   o_out, 32'd0);
    chk("rst_amt",   {26'd0, o_amt}, 32'd0);
    chk("rst_zero",  {31'd0, o_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("one",  32'h0000_0001, 1'b0);
    chk("one_amt31", {26'd0, o_amt}, 32'd31);
    run_op("zero", 32'h0000_0000, 1'b0);
    chk("zero_amt32", {26'd0, o_amt}, 32'd32);
    run_op("msb",  32'h8000_0000, 1'b0);
    run_op("f0",   32'h00F0_0000, 1'b0);
    chk("f0_out", o_out, 32'hF000_0000);
`ifdef NORM_CTZ_EN
    run_op("tz_a00", 32'h0000_0A00, 1'b1);
    chk("tz_a00_out", o_out, 32'h0000_0005);
    run_op("tz_zero", 32'h0000_0000, 1'b1);
    run_op("tz_msb",  32'h8000_0000, 1'b1);
`endif

    // Backpressure hold, plus a stray i_valid pulse during RUN
    wait_ready();
    i_in    = 32'h0000_3000;
    i_valid = 1'b1;
`ifdef NORM_CTZ_EN
    dir     = 1'b0;
`endif
    tick();
    i_valid = 1'b0;
    tick();
    i_in    = 32'hFFFF_FFFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    tick();
    check_result("hold", 32'h0000_3000, 1'b0);
    h_out = o_out;
    h_amt = o_amt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out",   o_out, h_out);
      chk("hold_amt",   {26'd0, o_amt}, {26'd0, h_amt});
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_ready", {31'd0, o_ready}, 32'd0);
    end
    chk("hold_out_ref", o_out, 32'hC000_0000);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("hold_rel_ready", {31'd0, o_ready}, 32'd1);

    // Reset mid-RUN aborts the operation
    i_in    = 32'h0000_0040;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_ready", {31'd0, o_ready}, 32'd1);
    chk("arst_out",   o_out, 32'd0);
    chk("arst_amt",   {26'd0, o_amt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 32'h0001_0000, 1'b0);
    chk("post_rst_amt15", {26'd0, o_amt}, 32'd15);

    for (int n = 0; n < 40; n++) begin
      r = $urandom >> $urandom_range(0, 32);
`ifdef NORM_CTZ_EN
      if (n % 2 == 1) r = $urandom << $urandom_range(0, 32);
      run_op("rand", r, n[0]);
`else
      run_op("rand", r, 1'b0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
